// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: 5-8 data bits, optional odd/even parity, 1 or 2 stop bits.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 majority of ticks 6/7/8 instead of a single tick-7 sample.
module uart_rx #(
    parameter int DLY        = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [3:0]            data_bits,
    input  logic [1:0]            parity_mode,
    input  logic [1:0]            stop_bits,
    input  logic                  br16_en_i,
    input  logic                  rx_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_vld_o,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  rx_busy_o
);

    typedef enum logic [5:0] {
        IDLE   = 6'b000001,
        START  = 6'b000010,
        DATA   = 6'b000100,
        PARITY = 6'b001000,
        STOP   = 6'b010000,
        BREAK  = 6'b100000
    } state_t;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] DEC_TICK = 4'd8;
`else
    localparam logic [3:0] DEC_TICK = 4'd7;
`endif

    state_t     state_q, state_d;
    logic       rx_meta, rx_s;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic       stop_cnt;
    logic [2:0] last_bit, last_bit_in;
    logic [1:0] par_cfg;
    logic       two_stop;
    logic [7:0] shift_q;
    logic       par_err_q, frame_err_q;
    logic       bit_val, decide, wrap, start_det, stop_done, frame_err_now;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic samp6, samp7;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            samp6 <= 1'b1;
            samp7 <= 1'b1;
        end else if (br16_en_i) begin
            if (tick_cnt == 4'd6) samp6 <= rx_s;
            if (tick_cnt == 4'd7) samp7 <= rx_s;
        end
    end

    assign bit_val = (samp6 & samp7) | (samp6 & rx_s) | (samp7 & rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign decide        = br16_en_i && (tick_cnt == DEC_TICK);
    assign wrap          = br16_en_i && (tick_cnt == 4'hF);
    assign start_det     = (state_q == IDLE) && !rx_s;
    assign stop_done     = (state_q == STOP) && decide && (stop_cnt == two_stop);
    assign frame_err_now = frame_err_q | ~bit_val;
    assign rx_busy_o     = (state_q != IDLE);

    always_comb begin
        last_bit_in = 3'd7;
        if (data_bits < 4'd5)      last_bit_in = 3'd4;
        else if (data_bits > 4'd8) last_bit_in = 3'd7;
        else                       last_bit_in = 3'(data_bits - 4'd1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (!rx_s) state_d = START;
            START: begin
                if (decide && bit_val) state_d = IDLE;
                else if (wrap)         state_d = DATA;
            end
            DATA:   if (wrap && bit_cnt == last_bit) state_d = par_cfg[1] ? STOP : PARITY;
            PARITY: if (wrap) state_d = STOP;
            STOP:   if (stop_done) state_d = (frame_err_now && shift_q == 8'd0) ? BREAK : IDLE;
            BREAK:  if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame datapath; the result registers load on the edge that leaves STOP
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_cnt     <= 4'd0;
            bit_cnt      <= 3'd0;
            stop_cnt     <= 1'b0;
            last_bit     <= 3'd7;
            par_cfg      <= 2'b10;
            two_stop     <= 1'b0;
            shift_q      <= 8'd0;
            par_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_data_o    <= '0;
            rx_vld_o     <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            rx_vld_o <= 1'b0;
            if (start_det) begin
                tick_cnt    <= 4'd0;
                bit_cnt     <= 3'd0;
                stop_cnt    <= 1'b0;
                shift_q     <= 8'd0;
                par_err_q   <= 1'b0;
                frame_err_q <= 1'b0;
                last_bit    <= last_bit_in;
                par_cfg     <= parity_mode;
                two_stop    <= (stop_bits == 2'b01);
            end else if (br16_en_i && state_q != IDLE && state_q != BREAK) begin
                tick_cnt <= tick_cnt + 4'd1;
            end
            if (state_q == DATA && decide) shift_q[bit_cnt] <= bit_val;
            if (state_q == DATA && wrap)   bit_cnt <= bit_cnt + 3'd1;
            if (state_q == PARITY && decide)
                par_err_q <= (((^shift_q) ^ bit_val) == par_cfg[0]);
            if (state_q == STOP && decide && !bit_val) frame_err_q <= 1'b1;
            if (state_q == STOP && wrap)               stop_cnt <= 1'b1;
            if (stop_done) begin
                rx_data_o    <= DATA_WIDTH'(shift_q);
                rx_vld_o     <= 1'b1;
                parity_err_o <= par_err_q;
                frame_err_o  <= frame_err_now;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames for uart_rx, checked against a frame-level reference model.
module tb_uart_rx;

    localparam int DW           = 8;
    localparam int CLKS_PER_BIT = 64;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [3:0]    data_bits;
    logic [1:0]    parity_mode;
    logic [1:0]    stop_bits;
    logic          br16_en_i;
    logic          rx_i;
    logic [DW-1:0] rx_data_o;
    logic          rx_vld_o;
    logic          parity_err_o;
    logic          frame_err_o;
    logic          rx_busy_o;

    logic [1:0]    divCnt = 2'd0;
    longint        cycleCount = 0;
    int            vectors = 0;
    int            miscompares = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          pe;
        logic          fe;
        longint        cyc;
    } strobe_t;
    strobe_t strobes[$];

    uart_rx #(.DLY(1), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_i(rst_i), .data_bits(data_bits), .parity_mode(parity_mode),
        .stop_bits(stop_bits), .br16_en_i(br16_en_i), .rx_i(rx_i), .rx_data_o(rx_data_o),
        .rx_vld_o(rx_vld_o), .parity_err_o(parity_err_o), .frame_err_o(frame_err_o),
        .rx_busy_o(rx_busy_o)
    );

    always #5 clk = ~clk;

    // 16x baud enable: one clk pulse every 4 clk
    always @(posedge clk) begin
        divCnt     <= divCnt + 2'd1;
        br16_en_i  <= (divCnt == 2'd3);
        cycleCount <= cycleCount + 1;
    end

    always @(negedge clk) begin
        if (rx_vld_o) strobes.push_back('{rx_data_o, parity_err_o, frame_err_o, cycleCount});
    end

    function automatic int clampBits(input logic [3:0] db);
        if (db < 4'd5) return 5;
        if (db > 4'd8) return 8;
        return int'(db);
    endfunction

    function automatic logic [7:0] maskData(input logic [7:0] d, input int n);
        logic [7:0] m;
        m = 8'((1 << n) - 1);
        return d & m;
    endfunction

    function automatic logic parityBit(input logic [7:0] d, input int n, input logic [1:0] pm);
        int ones;
        ones = $countones(maskData(d, n));
        return (pm == 2'b01) ? logic'(ones % 2) : logic'((ones + 1) % 2);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic holdLine(input logic b, input int clks);
        rx_i = b;
        repeat (clks) @(negedge clk);
    endtask

    // One complete frame, optionally with a wrong parity bit, a short low first stop bit, or a 3-clk glitch mid-bit
    task automatic applyStimulus(input logic [7:0] d, input logic [3:0] db, input logic [1:0] pm,
                                 input logic [1:0] sb, input bit badPar, input bit badStop,
                                 input int glitchBit);
        int n;
        n = clampBits(db);
        data_bits   = db;
        parity_mode = pm;
        stop_bits   = sb;
        holdLine(1'b0, CLKS_PER_BIT);
        for (int i = 0; i < n; i++) begin
            if (i == glitchBit) begin
                holdLine(d[i], 31);
                holdLine(~d[i], 3);
                holdLine(d[i], 30);
            end else begin
                holdLine(d[i], CLKS_PER_BIT);
            end
        end
        if (!pm[1]) holdLine(parityBit(d, n, pm) ^ badPar, CLKS_PER_BIT);
        if (badStop) begin
            holdLine(1'b0, 40);
            holdLine(1'b1, 24);
        end else begin
            holdLine(1'b1, CLKS_PER_BIT);
        end
        if (sb == 2'b01) holdLine(1'b1, CLKS_PER_BIT);
    endtask

    task automatic expectStrobe(input string tag, input logic [7:0] expData, input logic expPe,
                                input logic expFe);
        int waited;
        strobe_t s;
        waited = 0;
        while (strobes.size() == 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, ".count"}, strobes.size(), 1);
        if (strobes.size() > 0) begin
            s = strobes.pop_front();
            checkOutput({tag, ".data"}, 32'(s.data), 32'(expData));
            checkOutput({tag, ".pe"}, 32'(s.pe), 32'(expPe));
            checkOutput({tag, ".fe"}, 32'(s.fe), 32'(expFe));
        end
        strobes.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic [3:0] db;
        logic [1:0] pm, sb;
        bit         bp;
        int         n;

        rst_i = 1'b1; rx_i = 1'b1; data_bits = 4'd8; parity_mode = 2'b10; stop_bits = 2'b00;
        repeat (3) @(negedge clk);
        checkOutput("reset.data", 32'(rx_data_o), 0);
        checkOutput("reset.vld", 32'(rx_vld_o), 0);
        checkOutput("reset.pe", 32'(parity_err_o), 0);
        checkOutput("reset.fe", 32'(frame_err_o), 0);
        checkOutput("reset.busy", 32'(rx_busy_o), 0);
        rst_i = 1'b0;
        holdLine(1'b1, 10);

        applyStimulus(8'hA5, 4'd8, 2'b10, 2'b00, 0, 0, -1);
        expectStrobe("8N1_A5", 8'hA5, 1'b0, 1'b0);

        applyStimulus(8'h3C, 4'd7, 2'b01, 2'b01, 1, 0, -1);
        expectStrobe("7E2_badpar", 8'h3C, 1'b1, 1'b0);
        applyStimulus(8'h3C, 4'd7, 2'b01, 2'b01, 0, 0, -1);
        expectStrobe("7E2_goodpar", 8'h3C, 1'b0, 1'b0);

        // Start glitch: 5 ticks low is rejected at the start bit's decision point
        holdLine(1'b0, 20);
        checkOutput("glitch.busy_during", 32'(rx_busy_o), 1);
        holdLine(1'b1, CLKS_PER_BIT);
        checkOutput("glitch.busy_after", 32'(rx_busy_o), 0);
        checkOutput("glitch.no_strobe", strobes.size(), 0);

        // Reset during data bit 3 of an 8N1 frame
        data_bits = 4'd8; parity_mode = 2'b10; stop_bits = 2'b00;
        holdLine(1'b0, CLKS_PER_BIT);
        holdLine(1'b0, CLKS_PER_BIT);
        holdLine(1'b1, CLKS_PER_BIT);
        holdLine(1'b0, CLKS_PER_BIT);
        holdLine(1'b1, 32);
        checkOutput("rst.busy_before", 32'(rx_busy_o), 1);
        rst_i = 1'b1;
        @(negedge clk);
        checkOutput("rst.data", 32'(rx_data_o), 0);
        checkOutput("rst.vld", 32'(rx_vld_o), 0);
        checkOutput("rst.pe", 32'(parity_err_o), 0);
        checkOutput("rst.fe", 32'(frame_err_o), 0);
        checkOutput("rst.busy", 32'(rx_busy_o), 0);
        rst_i = 1'b0;
        holdLine(1'b1, 2 * CLKS_PER_BIT);
        checkOutput("rst.no_strobe", strobes.size(), 0);
        applyStimulus(8'h81, 4'd8, 2'b10, 2'b00, 0, 0, -1);
        expectStrobe("after_rst_81", 8'h81, 1'b0, 1'b0);

        applyStimulus(8'h55, 4'd8, 2'b10, 2'b00, 0, 1, -1);
        expectStrobe("8N1_badstop", 8'h55, 1'b0, 1'b1);
        holdLine(1'b1, 2 * CLKS_PER_BIT);
        checkOutput("badstop.busy_after", 32'(rx_busy_o), 0);
        checkOutput("badstop.no_extra", strobes.size(), 0);

        // Line held low for three 8N1 frame times: one zero word with a frame error, then BREAK
        holdLine(1'b0, 3 * 10 * CLKS_PER_BIT);
        checkOutput("break.busy", 32'(rx_busy_o), 1);
        expectStrobe("break", 8'h00, 1'b0, 1'b1);
        holdLine(1'b1, 8);
        checkOutput("break.busy_after", 32'(rx_busy_o), 0);
        checkOutput("break.no_strobe", strobes.size(), 0);
        holdLine(1'b1, CLKS_PER_BIT);

        // Back-to-back 5O1 frames: 8 bits of 16 ticks each separate the strobes
        applyStimulus(8'h1F, 4'd5, 2'b00, 2'b00, 0, 0, -1);
        applyStimulus(8'h00, 4'd5, 2'b00, 2'b00, 0, 0, -1);
        holdLine(1'b1, 10);
        checkOutput("b2b.count", strobes.size(), 2);
        if (strobes.size() == 2) begin
            checkOutput("b2b.data0", 32'(strobes[0].data), 32'h1F);
            checkOutput("b2b.data1", 32'(strobes[1].data), 32'h00);
            checkOutput("b2b.flags", {30'd0, strobes[0].pe | strobes[1].pe, strobes[0].fe | strobes[1].fe}, 0);
            checkOutput("b2b.spacing", 32'(strobes[1].cyc - strobes[0].cyc), 32'(8 * 16 * 4));
        end
        strobes.delete();

        for (int k = 0; k < 10; k++) begin
            d  = 8'($urandom);
            db = 4'($urandom_range(0, 15));
            pm = 2'($urandom_range(0, 3));
            sb = 2'($urandom_range(0, 3));
            bp = 1'($urandom_range(0, 1));
            n  = clampBits(db);
            applyStimulus(d, db, pm, sb, bp, 0, -1);
            expectStrobe($sformatf("rand%0d", k), maskData(d, n), bp & ~pm[1], 1'b0);
            holdLine(1'b1, $urandom_range(1, 40));
        end

`ifdef UART_RX_MAJORITY_EN
        applyStimulus(8'hA5, 4'd8, 2'b10, 2'b00, 0, 0, 2);
        expectStrobe("majority_glitch", 8'hA5, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
